// File: rtl/mul_4bit_seq_pkg.sv
// Shared constants for the sequential 4x4 shift-add multiplier.
// Holds the operand width, the step-counter sizing and the FSM state encodings.
package mul_4bit_seq_pkg;

  localparam int N     = 4;
  localparam int CNT_W = $clog2(N);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple adder with carry in/out.
// Produces the partial-product sum for each multiplier step.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'd0, ci};

endmodule

// File: rtl/mul_4bit_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with valid/ready on both sides.
// One operand pair takes 4 CALC cycles; the product {A,Q} is held until the next accept.
module mul_4bit_seq
  import mul_4bit_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_p
);

  logic [1:0]       state_r;
  logic [3:0]       m_r;
  logic [3:0]       a_r;
  logic [3:0]       q_r;
  logic             c_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       addend_s;
  logic [3:0]       sum_s;
  logic             co_s;

  assign addend_s = q_r[0] ? m_r : 4'd0;

  // C is cleared on accept and after every step, so feeding it as carry-in is a plain add.
  adder_4bit u_add (
    .a  (a_r),
    .b  (addend_s),
    .ci (c_r),
    .s  (sum_s),
    .co (co_s)
  );

  // Control FSM: IDLE -> CALC (N steps) -> DONE -> IDLE on downstream handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (i_valid)             state_r <= ST_CALC;
        ST_CALC: if (cnt_r == CNT_LAST)   state_r <= ST_DONE;
        ST_DONE: if (i_ready)             state_r <= ST_IDLE;
        default:                          state_r <= ST_IDLE;
      endcase
    end
  end

  // Datapath: load operands on accept, then one shift-add step per CALC cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      m_r   <= 4'd0;
      a_r   <= 4'd0;
      q_r   <= 4'd0;
      c_r   <= 1'b0;
      cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            m_r   <= i_a;
            q_r   <= i_b;
            a_r   <= 4'd0;
            c_r   <= 1'b0;
            cnt_r <= '0;
          end
        end
        ST_CALC: begin
          a_r   <= {co_s, sum_s[3:1]};
          q_r   <= {sum_s[0], q_r[3:1]};
          c_r   <= 1'b0;
          cnt_r <= cnt_r + CNT_ONE;
        end
        default: begin
          // DONE holds every register until the product is taken.
        end
      endcase
    end
  end

  assign o_ready = (state_r == ST_IDLE);
  assign o_valid = (state_r == ST_DONE);
  assign o_p     = {a_r, q_r};

endmodule
